// File: rtl/score_mem_pkg.sv
// Shared types and helpers for the score-memory bank arbiter.
package score_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    BANK0     = 2'd0,
    BANK1     = 2'd1,
    BANK_NONE = 2'd2
  } bank_id_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Inclusive window check, done in signed int so a zero lower bound
  // does not turn into an always-true unsigned compare.
  function automatic logic in_window(input logic [31:0] addr, input int lower, input int upper);
    int a;
    a = int'(addr);
    return (a >= lower) && (a <= upper);
  endfunction

endpackage

// File: rtl/score_bank_port.sv
// One score bank: window decode for both requesters, round-robin winner
// selection on a same-bank collision, and the bank drive mux.
module score_bank_port
  import score_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOWER      = 0,
  parameter int UPPER      = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic                  i_we_a,
  input  logic [DATA_WIDTH-1:0] i_wdata_a,
  input  logic                  i_req_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic                  i_we_b,
  input  logic [DATA_WIDTH-1:0] i_wdata_b,
  output logic                  o_hit_a,
  output logic                  o_hit_b,
  output logic                  o_gnt_a,
  output logic                  o_gnt_b,
  output logic                  o_collision,
  output logic                  o_en,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata
);

  localparam logic [ADDR_WIDTH-1:0] LOWER_ADDR = ADDR_WIDTH'(LOWER);

  req_id_t r_rr_ptr;
  logic    w_req_a;
  logic    w_req_b;

  assign o_hit_a = in_window(32'(i_addr_a), LOWER, UPPER);
  assign o_hit_b = in_window(32'(i_addr_b), LOWER, UPPER);

  // Requests targeting this bank; nothing is granted while reset is held.
  assign w_req_a = i_rst_n & i_req_a & o_hit_a;
  assign w_req_b = i_rst_n & i_req_b & o_hit_b;

  assign o_collision = w_req_a & w_req_b;
  assign o_gnt_a     = w_req_a & (~w_req_b | (r_rr_ptr == REQ_A));
  assign o_gnt_b     = w_req_b & (~w_req_a | (r_rr_ptr == REQ_B));

  // Drive the bank from whichever requester holds the grant; idle bank is all-zero.
  always_comb begin
    o_en    = 1'b0;
    o_we    = 1'b0;
    o_addr  = '0;
    o_wdata = '0;
    if (o_gnt_a) begin
      o_en    = 1'b1;
      o_we    = i_we_a;
      o_addr  = i_addr_a - LOWER_ADDR;
      o_wdata = i_wdata_a;
    end else if (o_gnt_b) begin
      o_en    = 1'b1;
      o_we    = i_we_b;
      o_addr  = i_addr_b - LOWER_ADDR;
      o_wdata = i_wdata_b;
    end
  end

  // Priority passes to the loser only when a collision actually happened.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr <= REQ_A;
    end else if (o_collision) begin
      r_rr_ptr <= (r_rr_ptr == REQ_A) ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/score_bank_arbiter.sv
// Two-requester, two-bank score memory arbiter: grants, read-return tags,
// out-of-window error reporting and a saturating collision counter.
module score_bank_arbiter
  import score_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOWER0     = 0,
  parameter int UPPER0     = 9,
  parameter int LOWER1     = 10,
  parameter int UPPER1     = 19,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic                  i_we_a,
  input  logic [DATA_WIDTH-1:0] i_wdata_a,
  input  logic                  i_req_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic                  i_we_b,
  input  logic [DATA_WIDTH-1:0] i_wdata_b,
  output logic                  o_gnt_a,
  output logic                  o_gnt_b,
  output logic                  o_rvalid_a,
  output logic                  o_rvalid_b,
  output logic [DATA_WIDTH-1:0] o_rdata_a,
  output logic [DATA_WIDTH-1:0] o_rdata_b,
  output logic                  o_err_a,
  output logic                  o_err_b,
  output logic                  o_b0_en,
  output logic                  o_b0_we,
  output logic [ADDR_WIDTH-1:0] o_b0_addr,
  output logic [DATA_WIDTH-1:0] o_b0_wdata,
  output logic                  o_b1_en,
  output logic                  o_b1_we,
  output logic [ADDR_WIDTH-1:0] o_b1_addr,
  output logic [DATA_WIDTH-1:0] o_b1_wdata,
  input  logic [DATA_WIDTH-1:0] i_b0_rdata,
  input  logic [DATA_WIDTH-1:0] i_b1_rdata,
  output logic [CNT_WIDTH-1:0]  o_conflict_cnt
);

  logic w_hit_a0, w_hit_b0, w_gnt_a0, w_gnt_b0, w_col0;
  logic w_hit_a1, w_hit_b1, w_gnt_a1, w_gnt_b1, w_col1;
  logic w_err_a, w_err_b;
  bank_id_t w_bank_a, w_bank_b;

  logic                 r_vld_a, r_vld_b;
  bank_id_t             r_bank_a, r_bank_b;
  logic [CNT_WIDTH-1:0] r_conflict_cnt;

  score_bank_port #(
    .ADDR_WIDTH (ADDR_WIDTH), .DATA_WIDTH (DATA_WIDTH), .LOWER (LOWER0), .UPPER (UPPER0)
  ) u_bank0 (
    .i_clk (i_clk), .i_rst_n (i_rst_n),
    .i_req_a (i_req_a), .i_addr_a (i_addr_a), .i_we_a (i_we_a), .i_wdata_a (i_wdata_a),
    .i_req_b (i_req_b), .i_addr_b (i_addr_b), .i_we_b (i_we_b), .i_wdata_b (i_wdata_b),
    .o_hit_a (w_hit_a0), .o_hit_b (w_hit_b0), .o_gnt_a (w_gnt_a0), .o_gnt_b (w_gnt_b0),
    .o_collision (w_col0), .o_en (o_b0_en), .o_we (o_b0_we), .o_addr (o_b0_addr),
    .o_wdata (o_b0_wdata)
  );

  score_bank_port #(
    .ADDR_WIDTH (ADDR_WIDTH), .DATA_WIDTH (DATA_WIDTH), .LOWER (LOWER1), .UPPER (UPPER1)
  ) u_bank1 (
    .i_clk (i_clk), .i_rst_n (i_rst_n),
    .i_req_a (i_req_a), .i_addr_a (i_addr_a), .i_we_a (i_we_a), .i_wdata_a (i_wdata_a),
    .i_req_b (i_req_b), .i_addr_b (i_addr_b), .i_we_b (i_we_b), .i_wdata_b (i_wdata_b),
    .o_hit_a (w_hit_a1), .o_hit_b (w_hit_b1), .o_gnt_a (w_gnt_a1), .o_gnt_b (w_gnt_b1),
    .o_collision (w_col1), .o_en (o_b1_en), .o_we (o_b1_we), .o_addr (o_b1_addr),
    .o_wdata (o_b1_wdata)
  );

  // Out-of-window accesses are accepted immediately and answered with an error.
  assign w_err_a = i_rst_n & i_req_a & ~w_hit_a0 & ~w_hit_a1;
  assign w_err_b = i_rst_n & i_req_b & ~w_hit_b0 & ~w_hit_b1;

  assign o_gnt_a = w_gnt_a0 | w_gnt_a1 | w_err_a;
  assign o_gnt_b = w_gnt_b0 | w_gnt_b1 | w_err_b;

  assign w_bank_a = w_gnt_a0 ? BANK0 : (w_gnt_a1 ? BANK1 : BANK_NONE);
  assign w_bank_b = w_gnt_b0 ? BANK0 : (w_gnt_b1 ? BANK1 : BANK_NONE);

  // Tag each granted read (or error) with its bank so the return can be routed next cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_a  <= 1'b0;
      r_vld_b  <= 1'b0;
      r_bank_a <= BANK_NONE;
      r_bank_b <= BANK_NONE;
    end else begin
      r_vld_a  <= w_err_a | ((w_gnt_a0 | w_gnt_a1) & ~i_we_a);
      r_vld_b  <= w_err_b | ((w_gnt_b0 | w_gnt_b1) & ~i_we_b);
      r_bank_a <= w_bank_a;
      r_bank_b <= w_bank_b;
    end
  end

  // Route returned bank data by tag; reset masks any read still in flight.
  always_comb begin
    o_rvalid_a = i_rst_n & r_vld_a;
    o_rvalid_b = i_rst_n & r_vld_b;
    o_err_a    = o_rvalid_a & (r_bank_a == BANK_NONE);
    o_err_b    = o_rvalid_b & (r_bank_b == BANK_NONE);
    o_rdata_a  = '0;
    o_rdata_b  = '0;
    if (o_rvalid_a) begin
      case (r_bank_a)
        BANK0:   o_rdata_a = i_b0_rdata;
        BANK1:   o_rdata_a = i_b1_rdata;
        default: o_rdata_a = '0;
      endcase
    end
    if (o_rvalid_b) begin
      case (r_bank_b)
        BANK0:   o_rdata_b = i_b0_rdata;
        BANK1:   o_rdata_b = i_b1_rdata;
        default: o_rdata_b = '0;
      endcase
    end
  end

  // Count collision cycles, sticking at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_conflict_cnt <= '0;
    end else if ((w_col0 | w_col1) && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_score_bank_arbiter.sv
// Bench for score_bank_arbiter: grant/drive vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_score_bank_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic b0_en, b0_we, b1_en, b1_we;
  logic [AW-1:0] b0_addr, b1_addr;
  logic [DW-1:0] b0_wdata, b1_wdata, b0_rdata, b1_rdata;
  logic [15:0] cnt;

  logic s_gnt_a, s_gnt_b, s_rvalid_a, s_rvalid_b, s_err_a, s_err_b;
  logic [DW-1:0] s_rdata_a, s_rdata_b, s_b0_wdata, s_b1_wdata;
  logic s_b0_en, s_b0_we, s_b1_en, s_b1_we;
  logic [AW-1:0] s_b0_addr, s_b1_addr;
  logic [1:0] cnt_s;

  score_bank_arbiter dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_req_a (req_a), .i_addr_a (addr_a), .i_we_a (we_a), .i_wdata_a (wdata_a),
    .i_req_b (req_b), .i_addr_b (addr_b), .i_we_b (we_b), .i_wdata_b (wdata_b),
    .o_gnt_a (gnt_a), .o_gnt_b (gnt_b), .o_rvalid_a (rvalid_a), .o_rvalid_b (rvalid_b),
    .o_rdata_a (rdata_a), .o_rdata_b (rdata_b), .o_err_a (err_a), .o_err_b (err_b),
    .o_b0_en (b0_en), .o_b0_we (b0_we), .o_b0_addr (b0_addr), .o_b0_wdata (b0_wdata),
    .o_b1_en (b1_en), .o_b1_we (b1_we), .o_b1_addr (b1_addr), .o_b1_wdata (b1_wdata),
    .i_b0_rdata (b0_rdata), .i_b1_rdata (b1_rdata), .o_conflict_cnt (cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  score_bank_arbiter #(.CNT_WIDTH (2)) dut_sat (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_req_a (req_a), .i_addr_a (addr_a), .i_we_a (we_a), .i_wdata_a (wdata_a),
    .i_req_b (req_b), .i_addr_b (addr_b), .i_we_b (we_b), .i_wdata_b (wdata_b),
    .o_gnt_a (s_gnt_a), .o_gnt_b (s_gnt_b), .o_rvalid_a (s_rvalid_a), .o_rvalid_b (s_rvalid_b),
    .o_rdata_a (s_rdata_a), .o_rdata_b (s_rdata_b), .o_err_a (s_err_a), .o_err_b (s_err_b),
    .o_b0_en (s_b0_en), .o_b0_we (s_b0_we), .o_b0_addr (s_b0_addr), .o_b0_wdata (s_b0_wdata),
    .o_b1_en (s_b1_en), .o_b1_we (s_b1_we), .o_b1_addr (s_b1_addr), .o_b1_wdata (s_b1_wdata),
    .i_b0_rdata (b0_rdata), .i_b1_rdata (b1_rdata), .o_conflict_cnt (cnt_s)
  );

  // Single-port BRAMs with one-cycle read latency, plus a bulk preload path.
  logic [DW-1:0] bram0 [16];
  logic [DW-1:0] bram1 [16];
  logic [DW-1:0] pl [20];
  logic pl_en = 1'b0;
  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 10; i++) begin
        bram0[i] <= pl[i];
        bram1[i] <= pl[i+10];
      end
    end else begin
      if (b0_en && b0_addr < 10) begin
        if (b0_we) bram0[b0_addr[3:0]] <= b0_wdata;
        else       b0_rdata <= bram0[b0_addr[3:0]];
      end
      if (b1_en && b1_addr < 10) begin
        if (b1_we) bram1[b1_addr[3:0]] <= b1_wdata;
        else       b1_rdata <= bram1[b1_addr[3:0]];
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic set_a(input logic r, input int ad, input logic w, input logic [31:0] d);
    req_a = r; addr_a = AW'(ad); we_a = w; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input int ad, input logic w, input logic [31:0] d);
    req_b = r; addr_b = AW'(ad); we_b = w; wdata_b = d;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; next(); next(); rst_n = 1;
  endtask

  task automatic preload();
    pl_en = 1; next(); pl_en = 0;
  endtask

  typedef struct {
    logic ra; int aa; logic wa; logic [31:0] da;
    logic rb; int ab; logic wb; logic [31:0] db;
    logic ga; logic gb;
    logic e0; logic w0; int ad0; logic [31:0] d0;
    logic e1; logic w1; int ad1; logic [31:0] d1;
  } vec_t;
  vec_t vecs[10];

  // Transaction-level model state
  logic [31:0] m_mem [20];
  int m_next_winner [2];
  int m_cnt, m_cnt_s, ba, bb, ia, ib;
  logic ga, gb, col, pend_a, pend_b;
  logic ev_a, ee_a, ev_b, ee_b;
  logic [31:0] ed_a, ed_b;

  function automatic int bank_of(input int ad);
    if (ad <= 9) return 0;
    if (ad <= 19) return 1;
    return 2;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    idle();
    for (int i = 0; i < 20; i++) pl[i] = '0;
    next();
    preload();
    do_reset();

    // reset-state outputs
    smp();
    chk("rst_gnt_a", gnt_a, 0); chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_cnt", cnt, 0);     chk("rst_b0_en", b0_en, 0);
    next();

    // ---- vector table: grant and bank drive ----
    vecs[0] = '{1, 3, 0, 0,              1, 12, 0, 0,              1, 1, 1, 0, 3, 0,              1, 0, 2, 0};
    vecs[1] = '{1, 9, 1, 32'h1111_0009,  1, 10, 0, 0,              1, 1, 1, 1, 9, 32'h1111_0009,  1, 0, 0, 0};
    vecs[2] = '{1, 19, 0, 0,             1, 0, 1, 32'h2222_0000,   1, 1, 1, 1, 0, 32'h2222_0000,  1, 0, 9, 0};
    vecs[3] = '{1, 20, 0, 0,             0, 0, 0, 0,               1, 0, 0, 0, 0, 0,              0, 0, 0, 0};
    vecs[4] = '{0, 0, 0, 0,              1, 15, 1, 32'h3333_000F,  0, 1, 0, 0, 0, 0,              1, 1, 5, 32'h3333_000F};
    vecs[5] = '{1, 5, 0, 0,              1, 7, 0, 0,               1, 0, 1, 0, 5, 0,              0, 0, 0, 0};
    vecs[6] = '{1, 1, 0, 0,              1, 8, 0, 0,               0, 1, 1, 0, 8, 0,              0, 0, 0, 0};
    vecs[7] = '{1, 13, 1, 32'h4444_000D, 1, 13, 1, 32'h5555_000D, 1, 0, 0, 0, 0, 0,              1, 1, 3, 32'h4444_000D};
    vecs[8] = '{1, 14, 0, 0,             1, 16, 0, 0,              0, 1, 0, 0, 0, 0,              1, 0, 6, 0};
    vecs[9] = '{1, 24, 0, 0,             1, 8191, 0, 0,            1, 1, 0, 0, 0, 0,              0, 0, 0, 0};
    for (int v = 0; v < 10; v++) begin
      set_a(vecs[v].ra, vecs[v].aa, vecs[v].wa, vecs[v].da);
      set_b(vecs[v].rb, vecs[v].ab, vecs[v].wb, vecs[v].db);
      smp();
      chk($sformatf("vec%0d_gnt_a", v), gnt_a, vecs[v].ga);
      chk($sformatf("vec%0d_gnt_b", v), gnt_b, vecs[v].gb);
      chk($sformatf("vec%0d_b0_en", v), b0_en, vecs[v].e0);
      chk($sformatf("vec%0d_b0_we", v), b0_we, vecs[v].w0);
      chk($sformatf("vec%0d_b0_addr", v), b0_addr, vecs[v].ad0);
      chk($sformatf("vec%0d_b0_wdata", v), b0_wdata, vecs[v].d0);
      chk($sformatf("vec%0d_b1_en", v), b1_en, vecs[v].e1);
      chk($sformatf("vec%0d_b1_we", v), b1_we, vecs[v].w1);
      chk($sformatf("vec%0d_b1_addr", v), b1_addr, vecs[v].ad1);
      chk($sformatf("vec%0d_b1_wdata", v), b1_wdata, vecs[v].d1);
      next();
      idle();
      next();
    end

    // ---- T1: disjoint parallel reads ----
    for (int i = 0; i < 20; i++) pl[i] = '0;
    pl[3] = 32'hAA; pl[12] = 32'hBB;
    do_reset();
    preload();
    set_a(1, 3, 0, 0); set_b(1, 12, 0, 0);
    smp();
    chk("t1_gnt_a", gnt_a, 1); chk("t1_gnt_b", gnt_b, 1);
    next(); idle();
    smp();
    chk("t1_rvalid_a", rvalid_a, 1); chk("t1_rdata_a", rdata_a, 32'hAA);
    chk("t1_rvalid_b", rvalid_b, 1); chk("t1_rdata_b", rdata_b, 32'hBB);
    chk("t1_err_a", err_a, 0);
    next();

    // ---- T2: bank0 collision, loser served next cycle ----
    do_reset();
    set_a(1, 5, 0, 0); set_b(1, 7, 0, 0);
    smp();
    chk("t2_c0_gnt_a", gnt_a, 1); chk("t2_c0_gnt_b", gnt_b, 0);
    next(); set_a(0, 0, 0, 0);
    smp();
    chk("t2_c1_gnt_b", gnt_b, 1); chk("t2_c1_cnt", cnt, 1);
    next(); idle();
    smp();
    chk("t2_cnt_hold", cnt, 1); chk("t2_rvalid_b", rvalid_b, 1);
    next();

    // ---- T3: continuous bank1 collisions alternate ----
    do_reset();
    set_a(1, 11, 0, 0); set_b(1, 15, 0, 0);
    for (int c = 0; c < 6; c++) begin
      smp();
      chk($sformatf("t3_c%0d_gnt_a", c), gnt_a, (c % 2 == 0) ? 1 : 0);
      chk($sformatf("t3_c%0d_gnt_b", c), gnt_b, (c % 2 == 0) ? 0 : 1);
      next();
    end
    idle();
    smp();
    chk("t3_cnt", cnt, 6); chk("t3_cnt_sat", cnt_s, 3);
    next();

    // ---- T4: winner's write seen by loser's read ----
    for (int i = 0; i < 20; i++) pl[i] = '0;
    do_reset();
    preload();
    set_a(1, 4, 1, 32'h1234); set_b(1, 4, 0, 0);
    smp();
    chk("t4_gnt_a", gnt_a, 1); chk("t4_gnt_b", gnt_b, 0); chk("t4_b0_we", b0_we, 1);
    next(); set_a(0, 0, 0, 0);
    smp();
    chk("t4_gnt_b_next", gnt_b, 1); chk("t4_no_rvalid_a", rvalid_a, 0);
    next(); idle();
    smp();
    chk("t4_rvalid_b", rvalid_b, 1); chk("t4_rdata_b", rdata_b, 32'h1234);
    next();

    // ---- T5: out-of-window read ----
    do_reset();
    set_a(1, 25, 0, 0);
    smp();
    chk("t5_gnt_a", gnt_a, 1); chk("t5_b0_en", b0_en, 0); chk("t5_b1_en", b1_en, 0);
    next(); idle();
    smp();
    chk("t5_rvalid_a", rvalid_a, 1); chk("t5_err_a", err_a, 1); chk("t5_rdata_a", rdata_a, 0);
    next();

    // ---- T6: reset discards in-flight read and restores priority ----
    do_reset();
    set_a(1, 5, 0, 0); set_b(1, 6, 0, 0);
    smp(); chk("t6_pre_gnt_a", gnt_a, 1);
    next(); set_a(0, 0, 0, 0);
    smp(); chk("t6_pre_gnt_b", gnt_b, 1);
    next(); idle(); set_a(1, 2, 0, 0);
    smp(); chk("t6_read_gnt", gnt_a, 1);
    next(); rst_n = 0;
    smp();
    chk("t6_rst_rvalid_a", rvalid_a, 0); chk("t6_rst_rdata_a", rdata_a, 0);
    chk("t6_rst_gnt_a", gnt_a, 0);       chk("t6_rst_b0_en", b0_en, 0);
    next(); next(); rst_n = 1; idle();
    smp();
    chk("t6_post_rvalid_a", rvalid_a, 0); chk("t6_post_cnt", cnt, 0);
    next(); set_a(1, 1, 0, 0); set_b(1, 3, 0, 0);
    smp();
    chk("t6_rr_gnt_a", gnt_a, 1); chk("t6_rr_gnt_b", gnt_b, 0);
    next(); idle(); next();

    // ---- randomized run against the transaction model ----
    for (int i = 0; i < 20; i++) begin
      pl[i] = $urandom;
      m_mem[i] = pl[i];
    end
    do_reset();
    preload();
    m_next_winner[0] = 0; m_next_winner[1] = 0;
    m_cnt = 0; m_cnt_s = 0;
    ev_a = 0; ee_a = 0; ed_a = 0; ev_b = 0; ee_b = 0; ed_b = 0;
    pend_a = 0; pend_b = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_a) set_a($urandom_range(0, 3) != 0, $urandom_range(0, 24), 1'($urandom_range(0, 1)), $urandom);
      if (!pend_b) set_b($urandom_range(0, 3) != 0, $urandom_range(0, 24), 1'($urandom_range(0, 1)), $urandom);
      ia = int'(addr_a); ib = int'(addr_b);
      ba = bank_of(ia);  bb = bank_of(ib);
      ga = req_a; gb = req_b; col = 0;
      if (req_a && req_b && ba == bb && ba != 2) begin
        col = 1;
        ga = (m_next_winner[ba] == 0);
        gb = !ga;
        m_next_winner[ba] = ga ? 1 : 0;
      end
      smp();
      chk("rnd_gnt_a", gnt_a, ga);
      chk("rnd_gnt_b", gnt_b, gb);
      chk("rnd_b0_en", b0_en, (ga && ba == 0) || (gb && bb == 0));
      chk("rnd_b1_en", b1_en, (ga && ba == 1) || (gb && bb == 1));
      chk("rnd_rvalid_a", rvalid_a, ev_a); chk("rnd_err_a", err_a, ee_a); chk("rnd_rdata_a", rdata_a, ed_a);
      chk("rnd_rvalid_b", rvalid_b, ev_b); chk("rnd_err_b", err_b, ee_b); chk("rnd_rdata_b", rdata_b, ed_b);
      chk("rnd_cnt", cnt, m_cnt);
      chk("rnd_cnt_sat", cnt_s, m_cnt_s);
      ev_a = ga && (ba == 2 || !we_a); ee_a = ga && ba == 2; ed_a = '0;
      ev_b = gb && (bb == 2 || !we_b); ee_b = gb && bb == 2; ed_b = '0;
      if (ga && ba != 2 && !we_a) ed_a = m_mem[ia];
      if (gb && bb != 2 && !we_b) ed_b = m_mem[ib];
      if (ga && ba != 2 && we_a) m_mem[ia] = wdata_a;
      if (gb && bb != 2 && we_b) m_mem[ib] = wdata_b;
      if (col) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
      end
      pend_a = req_a && !ga;
      pend_b = req_b && !gb;
      next();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
